isq_issue_sel: RTL

//  Parametrised issue-select stage between the issue queue (ISQ) and register-fetch (RF).

---
 rtl/isq_pkg.sv | 22 ++
 rtl/isq_pick_first.sv | 41 ++++
 rtl/isq_issue_sel.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/isq_pkg.sv
// Shared constants for the issue-select stage: class bit positions in the
// per-line one-hot class field and functional-unit port numbering.
package isq_pkg;

    localparam int CLS_MULT = 0;
    localparam int CLS_ALU  = 1;
    localparam int CLS_ADDR = 2;
    localparam int CLS_BR   = 3;
    localparam int CLS_W    = 4;

    localparam int NUM_ALU_DEF = 2;
    localparam int NP          = NUM_ALU_DEF + 2;

    localparam int PORT_MULT = 0;
    localparam int PORT_ALU0 = 1;

    // ADDR always sits just above the last ALU port
    function automatic int port_addr(input int num_alu);
        return num_alu + 1;
    endfunction

endpackage

// File: rtl/isq_pick_first.sv
// Rotating find-first: lowest request at or after start (wrapping mod DEPTH)
// that is not masked by excl.
module isq_pick_first #(
    parameter int DEPTH    = 64,
    parameter int IDX_BITS = 6
) (
    input  logic [DEPTH-1:0]    req,
    input  logic [DEPTH-1:0]    excl,
    input  logic [IDX_BITS-1:0] start,
    output logic [DEPTH-1:0]    onehot,
    output logic [IDX_BITS-1:0] idx,
    output logic                found
);

    logic [DEPTH-1:0]    cand;
    logic [IDX_BITS:0]   sum;
    logic [IDX_BITS-1:0] pos;

    assign cand = req & ~excl;

    // scan from the far end back to start so the nearest hit wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (IDX_BITS+1)'(k);
            if (sum >= (IDX_BITS+1)'(DEPTH))
                sum = sum - (IDX_BITS+1)'(DEPTH);
            pos = sum[IDX_BITS-1:0];
            if (cand[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

    assign onehot = found ? (DEPTH'(1) << idx) : '0;

endmodule

// File: rtl/isq_issue_sel.sv
// Issue-select stage: one registered pick slot per FU port (MULT, ALUs, ADDR).
// Define ISQ_SEL_RR_EN to rotate ALU scan start; default is fixed priority.
module isq_issue_sel
    import isq_pkg::*;
#(
    parameter int ISQ_DEPTH     = 64,
    parameter int IDX_BITS      = 6,
    parameter int IS_INST_WIDTH = 66,
    parameter int NUM_ALU       = NUM_ALU_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_ALU+1:0]                   fu_rdy,
    input  logic [ISQ_DEPTH-1:0]                 isq_vld,
    input  logic [ISQ_DEPTH-1:0]                 isq_rdy,
    input  logic [ISQ_DEPTH-1:0]                 isq_wat,
    input  logic [CLS_W*ISQ_DEPTH-1:0]           isq_cls_flat,
    input  logic [IS_INST_WIDTH*ISQ_DEPTH-1:0]   isq_pkt_flat,
    output logic [NUM_ALU+1:0]                   iss_vld,
    output logic [IS_INST_WIDTH*(NUM_ALU+2)-1:0] iss_pkt_flat,
    output logic [IDX_BITS*(NUM_ALU+2)-1:0]      iss_idx_flat,
    output logic [ISQ_DEPTH-1:0]                 clr_wat,
    output logic                                 br_iss
);

    localparam int NPORT  = NUM_ALU + 2;
    localparam int P_ADDR = port_addr(NUM_ALU);

    logic [ISQ_DEPTH-1:0][CLS_W-1:0]         line_cls;
    logic [ISQ_DEPTH-1:0][IS_INST_WIDTH-1:0] line_pkt;
    logic [ISQ_DEPTH-1:0] base, el_mult, el_alu, el_alubr, el_addr, is_br;

    logic [NPORT-1:0]                     cap, found;
    logic [NPORT-1:0][ISQ_DEPTH-1:0]      req, excl, onehot;
    logic [NPORT-1:0][IDX_BITS-1:0]       start, pidx;
    logic [NPORT-1:0][IS_INST_WIDTH-1:0]  iss_pkt_q;
    logic [NPORT-1:0][IDX_BITS-1:0]       iss_idx_q;
    logic [IDX_BITS-1:0]                  alu_start;

    assign line_cls     = isq_cls_flat;
    assign line_pkt     = isq_pkt_flat;
    assign iss_pkt_flat = iss_pkt_q;
    assign iss_idx_flat = iss_idx_q;

    assign base = isq_vld & isq_rdy & isq_wat;

    for (genvar i = 0; i < ISQ_DEPTH; i++) begin : g_line
        assign el_mult[i]  = base[i] & line_cls[i][CLS_MULT];
        assign el_alu[i]   = base[i] & line_cls[i][CLS_ALU];
        assign el_alubr[i] = base[i] & (line_cls[i][CLS_ALU] | line_cls[i][CLS_BR]);
        assign el_addr[i]  = base[i] & line_cls[i][CLS_ADDR];
        assign is_br[i]    = line_cls[i][CLS_BR];
    end

    // a full slot can only take a new pick in the cycle its unit drains it
    assign cap = {NPORT{~rst & ~flush}} & (~iss_vld | fu_rdy);

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        if (p == PORT_MULT) begin : g_mult
            assign req[p]   = cap[p] ? el_mult : '0;
            assign excl[p]  = '0;
            assign start[p] = '0;
        end else if (p == P_ADDR) begin : g_addr
            assign req[p]   = cap[p] ? el_addr : '0;
            assign excl[p]  = '0;
            assign start[p] = '0;
        end else if (p == PORT_ALU0) begin : g_alu0
            assign req[p]   = cap[p] ? el_alubr : '0;
            assign excl[p]  = '0;
            assign start[p] = alu_start;
        end else begin : g_alun
            // stalled ALUs pick nothing, so they leave their line to later ALUs
            assign req[p]   = cap[p] ? el_alu : '0;
            assign excl[p]  = excl[p-1] | onehot[p-1];
            assign start[p] = alu_start;
        end

        isq_pick_first #(
            .DEPTH    (ISQ_DEPTH),
            .IDX_BITS (IDX_BITS)
        ) u_pick (
            .req    (req[p]),
            .excl   (excl[p]),
            .start  (start[p]),
            .onehot (onehot[p]),
            .idx    (pidx[p]),
            .found  (found[p])
        );
    end

    always_comb begin
        clr_wat = '0;
        for (int p = 0; p < NPORT; p++)
            clr_wat = clr_wat | onehot[p];
    end

    assign br_iss = |(onehot[PORT_ALU0] & is_br);

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld   <= '0;
            iss_pkt_q <= '0;
            iss_idx_q <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (flush) begin
                    iss_vld[p] <= 1'b0;
                end else if (cap[p]) begin
                    iss_vld[p] <= found[p];
                    if (found[p]) begin
                        iss_pkt_q[p] <= line_pkt[pidx[p]];
                        iss_idx_q[p] <= pidx[p];
                    end
                end
            end
        end
    end

`ifdef ISQ_SEL_RR_EN
    logic [IDX_BITS-1:0] rr_ptr, rr_nxt;
    logic                rr_upd;

    // the highest-numbered capturing ALU holds the last pick in scan order
    always_comb begin
        rr_upd = 1'b0;
        rr_nxt = rr_ptr;
        for (int p = PORT_ALU0; p <= NUM_ALU; p++) begin
            if (found[p]) begin
                rr_upd = 1'b1;
                rr_nxt = (pidx[p] == IDX_BITS'(ISQ_DEPTH - 1)) ? '0 : pidx[p] + IDX_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (rr_upd)
            rr_ptr <= rr_nxt;
    end

    assign alu_start = rr_ptr;
`else
    assign alu_start = '0;
`endif

endmodule
